// File: rtl/jt51_opsched.sv
// Slot sequencer and modulation-source decoder for the FM operator pipeline.
// Optional test hooks (test_freeze input, wrap_cnt output) under `JT51_OPSCHED_TEST_EN.
module jt51_opsched #(
    parameter int CHW = 3,
    parameter int FBW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
`ifdef JT51_OPSCHED_TEST_EN
    input  logic             test_freeze,
    output logic [7:0]       wrap_cnt,
`endif
    input  logic             wr_en,
    input  logic [CHW-1:0]   wr_ch,
    input  logic [2:0]       wr_con,
    input  logic [FBW-1:0]   wr_fb,
    output logic [CHW+1:0]   slot_cnt,
    output logic             zero,
    output logic             m1_enters,
    output logic             m2_enters,
    output logic             c1_enters,
    output logic             c2_enters,
    output logic [2:0]       con_I,
    output logic [FBW-1:0]   fb_II,
    output logic             use_prevprev1,
    output logic             use_prev1,
    output logic             use_prev2,
    output logic             use_internal_x,
    output logic             use_internal_y
);

    localparam int SW   = CHW + 2;
    localparam int NCH  = 1 << CHW;

    logic [2:0]     con_q [NCH];
    logic [2:0]     con_d [NCH];
    logic [FBW-1:0] fb_q  [NCH];
    logic [FBW-1:0] fb_d  [NCH];

    logic           start_q, start_d;
    logic [SW-1:0]  slot_cnt_q, slot_cnt_d;
    logic           zero_q, zero_d;
    logic [3:0]     enters_q, enters_d;
    logic [2:0]     con_i_q, con_i_d;
    logic [FBW-1:0] fb_i_q, fb_i_d;
    logic [FBW-1:0] fb_ii_q, fb_ii_d;
    logic [4:0]     use_q, use_d;

    logic           step;
    logic [SW-1:0]  slot_nxt;
    logic [1:0]     grp;
    logic [CHW-1:0] ch;
    logic [2:0]     con_rd;
    logic [7:0]     a;
    logic           m1, m2, c1, c2;

    // Per-channel CON/FB storage; writes land at the edge but the decode below
    // reads the pre-write value, so a same-edge write waits for the next visit.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            always_comb begin
                con_d[gi] = con_q[gi];
                fb_d[gi]  = fb_q[gi];
                if (cen && wr_en && (wr_ch == CHW'(gi))) begin
                    con_d[gi] = wr_con;
                    fb_d[gi]  = wr_fb;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    con_q[gi] <= '0;
                    fb_q[gi]  <= '0;
                end else begin
                    con_q[gi] <= con_d[gi];
                    fb_q[gi]  <= fb_d[gi];
                end
            end
        end
    endgenerate

    always_comb begin
`ifdef JT51_OPSCHED_TEST_EN
        step = cen & ~test_freeze;
`else
        step = cen;
`endif
        // The first advancing edge after reset loads slot 0 with a full decode.
        slot_nxt = start_q ? slot_cnt_q + SW'(1) : '0;
        grp      = slot_nxt[SW-1:SW-2];
        ch       = slot_nxt[CHW-1:0];
        con_rd   = con_q[ch];
        a        = 8'd1 << con_rd;
        m1       = (grp == 2'd0);
        m2       = (grp == 2'd1);
        c1       = (grp == 2'd2);
        c2       = (grp == 2'd3);

        start_d    = start_q;
        slot_cnt_d = slot_cnt_q;
        zero_d     = zero_q;
        enters_d   = enters_q;
        con_i_d    = con_i_q;
        fb_i_d     = fb_i_q;
        fb_ii_d    = fb_ii_q;
        use_d      = use_q;

        if (step) begin
            start_d    = 1'b1;
            slot_cnt_d = slot_nxt;
            zero_d     = (slot_nxt == '0);
            enters_d   = {c2, c1, m2, m1};
            con_i_d    = con_rd;
            fb_i_d     = m1 ? fb_q[ch] : '0;
            fb_ii_d    = fb_i_q;
            use_d[4]   = m1 | (m2 & a[5]);
            use_d[3]   = m1 | (m2 & a[1]) | (c1 & (a[0] | a[3] | a[4] | a[5] | a[6]))
                       | (c2 & (a[2] | a[5]));
            use_d[2]   = (m2 & (a[0] | a[1] | a[2])) | (c2 & a[3]);
            use_d[1]   = c2 & a[2];
            use_d[0]   = c2 & (a[0] | a[1] | a[3] | a[4]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q    <= 1'b0;
            slot_cnt_q <= '0;
            zero_q     <= 1'b1;
            enters_q   <= 4'b0001;
            con_i_q    <= '0;
            fb_i_q     <= '0;
            fb_ii_q    <= '0;
            use_q      <= '0;
        end else begin
            start_q    <= start_d;
            slot_cnt_q <= slot_cnt_d;
            zero_q     <= zero_d;
            enters_q   <= enters_d;
            con_i_q    <= con_i_d;
            fb_i_q     <= fb_i_d;
            fb_ii_q    <= fb_ii_d;
            use_q      <= use_d;
        end
    end

`ifdef JT51_OPSCHED_TEST_EN
    logic [7:0] wrap_cnt_q, wrap_cnt_d;

    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (step && start_q && (slot_cnt_q == '1) && (wrap_cnt_q != 8'hFF))
            wrap_cnt_d = wrap_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wrap_cnt_q <= '0;
        else
            wrap_cnt_q <= wrap_cnt_d;
    end

    assign wrap_cnt = wrap_cnt_q;
`endif

    assign slot_cnt       = slot_cnt_q;
    assign zero           = zero_q;
    assign m1_enters      = enters_q[0];
    assign m2_enters      = enters_q[1];
    assign c1_enters      = enters_q[2];
    assign c2_enters      = enters_q[3];
    assign con_I          = con_i_q;
    assign fb_II          = fb_ii_q;
    assign use_prevprev1  = use_q[4];
    assign use_prev1      = use_q[3];
    assign use_prev2      = use_q[2];
    assign use_internal_x = use_q[1];
    assign use_internal_y = use_q[0];

endmodule

// File: tb/tb_jt51_opsched.sv
// Scoreboard bench for jt51_opsched: a behavioural slot model pushes the expected
// output vector per clock, each scenario task pops and compares it.
module tb_jt51_opsched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_ch = '0;
    logic [2:0] wr_con = '0;
    logic [2:0] wr_fb = '0;
    logic [4:0] slot_cnt;
    logic       zero, m1_enters, m2_enters, c1_enters, c2_enters;
    logic [2:0] con_I, fb_II;
    logic       use_prevprev1, use_prev1, use_prev2, use_internal_x, use_internal_y;
`ifdef JT51_OPSCHED_TEST_EN
    logic       test_freeze = 1'b0;
    logic [7:0] wrap_cnt;
`endif

    jt51_opsched dut (
        .clk(clk), .rst_n(rst_n), .cen(cen),
`ifdef JT51_OPSCHED_TEST_EN
        .test_freeze(test_freeze), .wrap_cnt(wrap_cnt),
`endif
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_con(wr_con), .wr_fb(wr_fb),
        .slot_cnt(slot_cnt), .zero(zero),
        .m1_enters(m1_enters), .m2_enters(m2_enters),
        .c1_enters(c1_enters), .c2_enters(c2_enters),
        .con_I(con_I), .fb_II(fb_II),
        .use_prevprev1(use_prevprev1), .use_prev1(use_prev1), .use_prev2(use_prev2),
        .use_internal_x(use_internal_x), .use_internal_y(use_internal_y)
    );

    always #5 clk = ~clk;

    // {slot, zero, m1, m2, c1, c2, con_I, fb_II, pp1, p1, p2, ix, iy}
    logic [20:0] obs;
    assign obs = {slot_cnt, zero, m1_enters, m2_enters, c1_enters, c2_enters, con_I, fb_II,
                  use_prevprev1, use_prev1, use_prev2, use_internal_x, use_internal_y};

    localparam logic [20:0] RST_VEC = {5'd0, 1'b1, 4'b1000, 3'd0, 3'd0, 5'd0};

    logic [20:0] sb_q[$];
    int          vec_cnt = 0;
    int          err_cnt = 0;

    int          m_slot;
    bit          m_started;
    logic [2:0]  m_con [8];
    logic [2:0]  m_fb  [8];
    logic [2:0]  m_fbi;
    logic [20:0] m_out;

    task automatic model_reset();
        m_slot = 0; m_started = 0; m_fbi = '0; m_out = RST_VEC;
        for (int i = 0; i < 8; i++) begin m_con[i] = '0; m_fb[i] = '0; end
        sb_q.delete();
    endtask

    // Drive one clock of stimulus and push the model's expected result.
    task automatic tick(input bit c, input bit we, input int ch, input int con, input int fb);
        int s, g, n;
        logic [2:0] cc, fbii;
        bit pp1, p1, p2, ix, iy;
        cen = c; wr_en = we; wr_ch = 3'(ch); wr_con = 3'(con); wr_fb = 3'(fb);
        if (c) begin
            s = m_started ? (m_slot + 1) % 32 : 0;
            m_started = 1; m_slot = s;
            g = s / 8; n = s % 8; cc = m_con[n];
            pp1 = (g == 0) || (g == 1 && cc == 5);
            p2  = (g == 1 && cc <= 2) || (g == 3 && cc == 3);
            ix  = (g == 3 && cc == 2);
            iy  = (g == 3 && (cc == 0 || cc == 1 || cc == 3 || cc == 4));
            p1  = (g == 0) || (g == 1 && cc == 1)
               || (g == 2 && (cc == 0 || cc == 3 || cc == 4 || cc == 5 || cc == 6))
               || (g == 3 && (cc == 2 || cc == 5));
            fbii = m_fbi;
            m_fbi = (g == 0) ? m_fb[n] : 3'd0;
            m_out = {5'(s), s == 0, g == 0, g == 1, g == 2, g == 3, cc, fbii,
                     pp1, p1, p2, ix, iy};
            if (we) begin m_con[ch] = 3'(con); m_fb[ch] = 3'(fb); end
        end
        sb_q.push_back(m_out);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        vec_cnt++;
        if (obs !== RST_VEC) begin
            err_cnt++;
            $display("FAIL reset obs=%h exp=%h", obs, RST_VEC);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        logic [20:0] e;
        for (int i = 0; i < 40; i++) begin
            tick(1, 0, 0, 0, 0);
            e = sb_q.pop_front(); vec_cnt++;
            if (obs !== e) begin
                err_cnt++;
                $display("FAIL free_run i=%0d obs=%h exp=%h", i, obs, e);
            end
            $display("free_run slot=%0d zero=%b m1=%b c1=%b", slot_cnt, zero, m1_enters, c1_enters);
        end
    endtask

    task automatic test_ch3_con7();
        logic [20:0] e;
        tick(1, 1, 3, 7, 5);
        e = sb_q.pop_front();
        for (int i = 0; i < 33; i++) begin
            tick(1, 0, 0, 0, 0);
            e = sb_q.pop_front(); vec_cnt++;
            if (obs !== e) begin
                err_cnt++;
                $display("FAIL ch3_con7 slot=%0d obs=%h exp=%h", slot_cnt, obs, e);
            end
            if (slot_cnt == 5'd3) begin
                vec_cnt++;
                if ({use_prevprev1, use_prev1} !== 2'b11) begin
                    err_cnt++;
                    $display("FAIL ch3_slot3 sel=%b exp=11", {use_prevprev1, use_prev1});
                end
            end
            if (slot_cnt == 5'd4) begin
                vec_cnt++;
                if (fb_II !== 3'd5) begin
                    err_cnt++;
                    $display("FAIL ch3_fb fb_II=%0d exp=5", fb_II);
                end
            end
            if (slot_cnt == 5'd11 || slot_cnt == 5'd27) begin
                vec_cnt++;
                if (obs[4:0] !== 5'b0) begin
                    err_cnt++;
                    $display("FAIL ch3_sel0 slot=%0d sel=%b exp=00000", slot_cnt, obs[4:0]);
                end
            end
        end
    endtask

    task automatic test_ch0_con2();
        logic [20:0] e;
        tick(1, 1, 0, 2, 0);
        e = sb_q.pop_front();
        for (int i = 0; i < 33; i++) begin
            tick(1, 0, 0, 0, 0);
            e = sb_q.pop_front(); vec_cnt++;
            if (obs !== e) begin
                err_cnt++;
                $display("FAIL ch0_con2 slot=%0d obs=%h exp=%h", slot_cnt, obs, e);
            end
            if (slot_cnt == 5'd24) begin
                vec_cnt++;
                if ({use_internal_x, use_prev1, use_internal_y} !== 3'b110) begin
                    err_cnt++;
                    $display("FAIL ch0_slot24 x/p1/y=%b exp=110",
                             {use_internal_x, use_prev1, use_internal_y});
                end
            end
            if (slot_cnt == 5'd8) begin
                vec_cnt++;
                if (use_prev2 !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL ch0_slot8 use_prev2=%b exp=1", use_prev2);
                end
            end
        end
    endtask

    task automatic test_same_edge_write();
        logic [20:0] e;
        int guard;
        guard = 0;
        while (((m_slot + 1) % 32) != 5 && guard < 40) begin
            tick(1, 0, 0, 0, 0);
            e = sb_q.pop_front();
            guard++;
        end
        tick(1, 1, 5, 4, 0);
        e = sb_q.pop_front(); vec_cnt++;
        if (obs !== e || con_I !== 3'd0) begin
            err_cnt++;
            $display("FAIL same_edge slot=%0d con_I=%0d exp_con=0 obs=%h exp=%h", slot_cnt, con_I, obs, e);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1, 0, 0, 0, 0);
            e = sb_q.pop_front(); vec_cnt++;
            if (obs !== e) begin
                err_cnt++;
                $display("FAIL same_edge_run slot=%0d obs=%h exp=%h", slot_cnt, obs, e);
            end
        end
        vec_cnt++;
        if (slot_cnt !== 5'd13 || con_I !== 3'd4) begin
            err_cnt++;
            $display("FAIL same_edge_slot13 slot=%0d con_I=%0d exp slot=13 con=4", slot_cnt, con_I);
        end
    endtask

    task automatic test_cen_toggle();
        logic [20:0] e;
        for (int i = 0; i < 70; i++) begin
            if (i[0]) tick(1, 0, 0, 0, 0);
            else      tick(0, (i == 4), 1, 6, 7);
            e = sb_q.pop_front(); vec_cnt++;
            if (obs !== e) begin
                err_cnt++;
                $display("FAIL cen_toggle i=%0d obs=%h exp=%h", i, obs, e);
            end
            if (i[0] && slot_cnt == 5'd9) begin
                vec_cnt++;
                if (use_prev2 !== 1'b1 || con_I !== 3'd0) begin
                    err_cnt++;
                    $display("FAIL cen0_write use_prev2=%b con_I=%0d exp 1/0", use_prev2, con_I);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [20:0] e;
        int guard;
        guard = 0;
        while (m_slot != 19 && guard < 40) begin
            tick(1, 0, 0, 0, 0);
            e = sb_q.pop_front();
            guard++;
        end
        vec_cnt++;
        if (slot_cnt !== 5'd19) begin
            err_cnt++;
            $display("FAIL arst_pre slot=%0d exp=19", slot_cnt);
        end
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (obs !== RST_VEC) begin
            err_cnt++;
            $display("FAIL arst obs=%h exp=%h", obs, RST_VEC);
        end
        model_reset();
        #1 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1, 0, 0, 0, 0);
            e = sb_q.pop_front(); vec_cnt++;
            if (obs !== e) begin
                err_cnt++;
                $display("FAIL arst_run i=%0d obs=%h exp=%h", i, obs, e);
            end
        end
    endtask

    initial begin
        model_reset();
        #12;
        test_reset();
        test_free_run();
        test_ch3_con7();
        test_ch0_con2();
        test_same_edge_write();
        test_cen_toggle();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/jt51_opsched.md
Name: jt51_opsched

Overview:
- Slot sequencer and modulation controller for the pipelined FM operator datapath.
- Runs the 32-slot operator cycle: 4 operator groups x 8 channels.
- Holds per-channel algorithm (CON) and feedback (FB) settings written by the register interface.
- Each cycle it issues the group-entry strobes, the five modulation-source selects and a stage-aligned con/fb to the operator pipeline.

Parameters:
- CHW, 3, channel index width (8 channels).
- FBW, 3, feedback field width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  clock enable; all state advances only when high
- wr_en  in  1  per-channel register write strobe
- wr_ch  in  3  channel written
- wr_con  in  3  algorithm 0-7
- wr_fb  in  3  feedback level 0-7
- slot_cnt  out  5  current slot in stage I: group=[4:3] (0=M1, 1=M2, 2=C1, 3=C2), ch=[2:0]
- zero  out  1  high while slot_cnt==0
- m1_enters  out  1  group==0
- m2_enters  out  1  group==1
- c1_enters  out  1  group==2
- c2_enters  out  1  group==3
- con_I  out  3  CON of current channel, stage I
- fb_II  out  3  FB of the channel in stage II, i.e. the previous slot
- use_prevprev1, use_prev1, use_prev2, use_internal_x, use_internal_y  out  1 each  modulation selects, stage I

Behaviour:
- Reset values:
  - slot_cnt=0, zero=1, m1_enters=1, other *_enters=0.
  - con_I=0, fb_II=0, all use_*=0.
  - CON/FB registers for all 8 channels = 0.
- Slot counter:
  - 5-bit; increments by 1 on each clk edge with cen=1.
  - Wraps 31->0 with no gap; holds when cen=0.
- Strobes and selects:
  - All *_enters, zero, con_I and use_* are registered.
  - They reflect the new slot_cnt on the same edge it changes (no combinational path from slot_cnt).
- Modulation decode (a = one-hot of CON, a[n]=1 when con==n); each select is the OR of the listed terms:
  - use_prevprev1 = m1 | (m2 & a5)
  - use_prev2 = (m2 & (a0|a1|a2)) | (c2 & a3)
  - use_internal_x = c2 & a2
  - use_internal_y = c2 & (a0|a1|a3|a4)
  - use_prev1 = m1 | (m2 & a1) | (c1 & (a0|a3|a4|a5|a6)) | (c2 & (a2|a5))
- fb_II:
  - FB of the channel of the previous slot, registered one cen-cycle after its con_I.
  - Forced to 0 when that slot was not M1.
- Register writes:
  - wr_en sampled on clk with cen=1 and takes effect at that edge.
  - A write to the channel being decoded on the same edge is NOT visible until the next slot of that channel; the decode uses the pre-write value.
  - Writes with cen=0 are ignored.
- Reset mid-cycle: asynchronously returns every output to its reset value immediately; the counter restarts at 0 on the first cen edge after release.

Optional Feature:
- JT51_OPSCHED_TEST_EN, when defined:
  - Adds input test_freeze (1).
  - While test_freeze=1 with cen=1, slot_cnt and all outputs hold, but register writes still apply.
  - Adds output wrap_cnt (8), a free-running count of 31->0 wraps, reset 0, saturating at 255.
- Without the macro: neither port exists, and behaviour is as above.

Test Plan:
- Reset release, cen=1 for 40 cycles:
  - slot_cnt runs 0..31 then 0..7.
  - zero is high only at 0.
  - m1_enters high for counts 0-7, c1_enters high for 16-23.
  - All use_* = 0 during M2/C1/C2 for CON=0 except as decoded.
- Write ch3 CON=7, FB=5, run a full cycle:
  - At slot 3: use_prevprev1=1, use_prev1=1.
  - At slot 4: fb_II=5.
  - At slot 11 (M2 ch3): all selects 0.
  - At slot 27: all selects 0.
- Write ch0 CON=2:
  - At slot 24: use_internal_x=1, use_prev1=1, use_internal_y=0.
  - At slot 8: use_prev2=1.
- Write ch5 CON=4 on the same edge slot_cnt becomes 5:
  - That slot decodes the old CON.
  - Slot 13 decodes CON=4.
- cen toggling 1/0 each cycle:
  - Counter advances every 2 clocks.
  - A write with cen=0 leaves the register unchanged.
- Assert rst_n low at slot 19: all outputs go to reset values asynchronously, before the next clk edge.
